hazard_forwarding_unit: RTL and testbench

HAZARD_FORWARDING_UNIT -- requirements
Module: hazard_forwarding_unit

---
 rtl/hazard_forwarding_unit.sv | 136 +++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline, with a
// memory-wait FSM that freezes the pipeline on slow data accesses.
module hazard_forwarding_unit #(
  parameter int NB_REG       = 5,
  parameter int NB_STALL_CNT = 16,
  parameter int MEM_TIMEOUT  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NB_REG-1:0]       rs_1_2,
  input  logic [NB_REG-1:0]       rt_1_2,
  input  logic                    branch_1_2,
  input  logic [NB_REG-1:0]       rs_2_3,
  input  logic [NB_REG-1:0]       rt_2_3,
  input  logic [NB_REG-1:0]       rd_2_3,
  input  logic                    register_write_2_3,
  input  logic                    mem_read_2_3,
  input  logic [NB_REG-1:0]       rd_3_4,
  input  logic                    register_write_3_4,
  input  logic                    mem_read_3_4,
  input  logic                    mem_access_3_4,
  input  logic [NB_REG-1:0]       rd_4_5,
  input  logic                    register_write_4_5,
  input  logic                    mem_ready,
  output logic [1:0]              control_muxA,
  output logic [1:0]              control_muxB,
  output logic [1:0]              control_branchA,
  output logic [1:0]              control_branchB,
  output logic                    stall_if_id,
  output logic                    flush_id_ex,
  output logic                    stall_all,
  output logic                    mem_error,
  output logic [NB_STALL_CNT-1:0] stall_count,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt, wait_d;
  logic       load_use, branch_hazard;

  // EX/MEM wins over MEM/WB; register 0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [NB_REG-1:0] src,
                                         input logic              mem_ok);
    if (mem_ok && register_write_3_4 && rd_3_4 != '0 && rd_3_4 == src)
      return 2'b01;
    if (register_write_4_5 && rd_4_5 != '0 && rd_4_5 == src)
      return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    control_muxA    = fwd_sel(rs_2_3, 1'b1);
    control_muxB    = fwd_sel(rt_2_3, 1'b1);
    control_branchA = fwd_sel(rs_1_2, !mem_read_3_4);
    control_branchB = fwd_sel(rt_1_2, !mem_read_3_4);
  end

  always_comb begin
    load_use = mem_read_2_3 && register_write_2_3 && rd_2_3 != '0 &&
               (rd_2_3 == rs_1_2 || rd_2_3 == rt_1_2);
    branch_hazard = branch_1_2 &&
      ((register_write_2_3 && rd_2_3 != '0 &&
        (rd_2_3 == rs_1_2 || rd_2_3 == rt_1_2)) ||
       (mem_read_3_4 && rd_3_4 != '0 &&
        (rd_3_4 == rs_1_2 || rd_3_4 == rt_1_2)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // The wait counter holds the number of MEM_WAIT cycles already spent
  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    case (state_q)
      RUN: begin
        if (enable && mem_access_3_4 && !mem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (enable) begin
          if (mem_ready) begin
            state_d = RUN;
          end else begin
            wait_d = wait_cnt + 8'd1;
            if (wait_cnt >= WAIT_LAST) state_d = ERROR;
          end
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_all = 1'b0;
    case (state_q)
      RUN:      stall_all = mem_access_3_4 && !mem_ready;
      MEM_WAIT: stall_all = !mem_ready;
      ERROR:    stall_all = 1'b1;
      default:  stall_all = 1'b0;
    endcase
    stall_if_id = (state_q == RUN) && !stall_all && (load_use || branch_hazard);
    flush_id_ex = stall_if_id;
    mem_error   = (state_q == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (enable && (stall_if_id || stall_all) && stall_count != '1) begin
      stall_count <= stall_count + {{(NB_STALL_CNT-1){1'b0}}, 1'b1};
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Self-checking bench for hazard_forwarding_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_forwarding_unit;

  localparam int NB_REG   = 5;
  localparam int NB_STALL = 6;
  localparam int TIMEOUT  = 8;
  localparam int CNT_MAX  = (1 << NB_STALL) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NB_REG-1:0] rs_1_2, rt_1_2, rs_2_3, rt_2_3, rd_2_3, rd_3_4, rd_4_5;
  logic              branch_1_2, register_write_2_3, mem_read_2_3;
  logic              register_write_3_4, mem_read_3_4, mem_access_3_4;
  logic              register_write_4_5, mem_ready;
  logic [1:0]        control_muxA, control_muxB, control_branchA, control_branchB;
  logic              stall_if_id, flush_id_ex, stall_all, mem_error;
  logic [NB_STALL-1:0] stall_count;
  logic [1:0]        state;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: 0 = running, 1 = waiting on memory, 2 = error
  int   m_state, m_waited, m_count;
  logic e_stall_all, e_stall, e_err;
  logic [1:0] e_muxA, e_muxB, e_brA, e_brB;
  int   saved;

  always #5 clk = ~clk;

  hazard_forwarding_unit #(
    .NB_REG(NB_REG), .NB_STALL_CNT(NB_STALL), .MEM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rs_1_2(rs_1_2), .rt_1_2(rt_1_2), .branch_1_2(branch_1_2),
    .rs_2_3(rs_2_3), .rt_2_3(rt_2_3), .rd_2_3(rd_2_3),
    .register_write_2_3(register_write_2_3), .mem_read_2_3(mem_read_2_3),
    .rd_3_4(rd_3_4), .register_write_3_4(register_write_3_4),
    .mem_read_3_4(mem_read_3_4), .mem_access_3_4(mem_access_3_4),
    .rd_4_5(rd_4_5), .register_write_4_5(register_write_4_5),
    .mem_ready(mem_ready),
    .control_muxA(control_muxA), .control_muxB(control_muxB),
    .control_branchA(control_branchA), .control_branchB(control_branchB),
    .stall_if_id(stall_if_id), .flush_id_ex(flush_id_ex),
    .stall_all(stall_all), .mem_error(mem_error),
    .stall_count(stall_count), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [NB_REG-1:0] src, input bit allow_mem);
    if (allow_mem && register_write_3_4 && rd_3_4 != 0 && rd_3_4 == src) return 2'b01;
    if (register_write_4_5 && rd_4_5 != 0 && rd_4_5 == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit src_hit_ex, src_hit_mem, load_use, branch;
    src_hit_ex  = rd_2_3 != 0 && (rd_2_3 == rs_1_2 || rd_2_3 == rt_1_2);
    src_hit_mem = rd_3_4 != 0 && (rd_3_4 == rs_1_2 || rd_3_4 == rt_1_2);
    load_use = mem_read_2_3 && register_write_2_3 && src_hit_ex;
    branch   = branch_1_2 && ((register_write_2_3 && src_hit_ex) || (mem_read_3_4 && src_hit_mem));
    if (m_state == 0)      e_stall_all = mem_access_3_4 && !mem_ready;
    else if (m_state == 1) e_stall_all = !mem_ready;
    else                   e_stall_all = 1'b1;
    e_stall = (m_state == 0) && !e_stall_all && (load_use || branch);
    e_err   = (m_state == 2);
    e_muxA  = exp_fwd(rs_2_3, 1'b1);
    e_muxB  = exp_fwd(rt_2_3, 1'b1);
    e_brA   = exp_fwd(rs_1_2, !mem_read_3_4);
    e_brB   = exp_fwd(rt_1_2, !mem_read_3_4);
  endtask

  task automatic model_clock();
    if (!enable) return;
    if ((e_stall || e_stall_all) && m_count < CNT_MAX) m_count++;
    if (m_state == 0) begin
      if (mem_access_3_4 && !mem_ready) begin
        m_state  = 1;
        m_waited = 0;
      end
    end else if (m_state == 1) begin
      if (mem_ready) m_state = 0;
      else begin
        m_waited++;
        if (m_waited == TIMEOUT) m_state = 2;
      end
    end
  endtask

  task automatic check_output();
    check("muxA", 32'(control_muxA), 32'(e_muxA));
    check("muxB", 32'(control_muxB), 32'(e_muxB));
    check("branchA", 32'(control_branchA), 32'(e_brA));
    check("branchB", 32'(control_branchB), 32'(e_brB));
    check("stall_if_id", 32'(stall_if_id), 32'(e_stall));
    check("flush_id_ex", 32'(flush_id_ex), 32'(e_stall));
    check("stall_all", 32'(stall_all), 32'(e_stall_all));
    check("mem_error", 32'(mem_error), 32'(e_err));
    check("stall_count", 32'(stall_count), 32'(m_count));
    check("state", 32'(state), 32'(m_state));
  endtask

  // One clock cycle: check mid-cycle, then advance the model with the DUT
  task automatic step();
    @(negedge clk);
    model_comb();
    check_output();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_idle();
    enable = 1'b1; mem_ready = 1'b1;
    rs_1_2 = '0; rt_1_2 = '0; rs_2_3 = '0; rt_2_3 = '0;
    rd_2_3 = '0; rd_3_4 = '0; rd_4_5 = '0;
    branch_1_2 = 1'b0; register_write_2_3 = 1'b0; mem_read_2_3 = 1'b0;
    register_write_3_4 = 1'b0; mem_read_3_4 = 1'b0; mem_access_3_4 = 1'b0;
    register_write_4_5 = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    #3;
    m_state = 0; m_waited = 0; m_count = 0;
    model_comb();
    check_output();
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(stall_count), 32'd0);
    check("reset_error", 32'(mem_error), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_comb();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_random();
    rs_1_2 = NB_REG'($urandom_range(0, 3)); rt_1_2 = NB_REG'($urandom_range(0, 3));
    rs_2_3 = NB_REG'($urandom_range(0, 3)); rt_2_3 = NB_REG'($urandom_range(0, 3));
    rd_2_3 = NB_REG'($urandom_range(0, 3)); rd_3_4 = NB_REG'($urandom_range(0, 3));
    rd_4_5 = NB_REG'($urandom_range(0, 3));
    branch_1_2 = 1'($urandom_range(0, 1));
    register_write_2_3 = 1'($urandom_range(0, 1)); mem_read_2_3 = 1'($urandom_range(0, 1));
    register_write_3_4 = 1'($urandom_range(0, 1)); mem_read_3_4 = 1'($urandom_range(0, 1));
    register_write_4_5 = 1'($urandom_range(0, 1));
    mem_access_3_4 = ($urandom_range(0, 3) == 0);
    mem_ready      = ($urandom_range(0, 3) != 0);
    enable         = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    #2;
    do_reset();

    // Load-use hazard stalls one cycle; rd 0 never stalls
    mem_read_2_3 = 1'b1; register_write_2_3 = 1'b1; rd_2_3 = 5'd7; rt_1_2 = 5'd7;
    #1;
    check("loaduse_stall", 32'(stall_if_id), 32'd1);
    check("loaduse_flush", 32'(flush_id_ex), 32'd1);
    step();
    check("loaduse_count", 32'(stall_count), 32'd1);
    rd_2_3 = 5'd0; rt_1_2 = 5'd0;
    #1;
    check("loaduse_r0", 32'(stall_if_id), 32'd0);
    step();
    set_idle();

    // ALU forwarding priority
    rd_3_4 = 5'd5; rd_4_5 = 5'd5; rs_2_3 = 5'd5;
    register_write_3_4 = 1'b1; register_write_4_5 = 1'b1;
    #1;
    check("fwd_exmem", 32'(control_muxA), 32'd1);
    step();
    register_write_3_4 = 1'b0;
    #1;
    check("fwd_memwb", 32'(control_muxA), 32'd2);
    step();
    set_idle();
    rs_2_3 = 5'd0;
    #1;
    check("fwd_none", 32'(control_muxA), 32'd0);
    step();

    // Branch behind a load stalls, then forwards from MEM/WB
    branch_1_2 = 1'b1; rs_1_2 = 5'd3; mem_read_3_4 = 1'b1; rd_3_4 = 5'd3;
    #1;
    check("branch_stall", 32'(stall_if_id), 32'd1);
    step();
    mem_read_3_4 = 1'b0; rd_3_4 = 5'd0; rd_4_5 = 5'd3; register_write_4_5 = 1'b1;
    #1;
    check("branch_fwd", 32'(control_branchA), 32'd2);
    check("branch_nostall", 32'(stall_if_id), 32'd0);
    step();

    // Three-cycle memory wait
    do_reset();
    mem_access_3_4 = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("memwait_stall", 32'(stall_all), 32'd1);
      check("memwait_state", 32'(state), i == 0 ? 32'd0 : 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("memwait_release", 32'(stall_all), 32'd0);
    step();
    mem_access_3_4 = 1'b0;
    #1;
    check("memwait_back", 32'(state), 32'd0);
    check("memwait_count", 32'(stall_count), 32'd3);

    // Access completing immediately causes no stall
    mem_access_3_4 = 1'b1; mem_ready = 1'b1;
    #1;
    check("fast_mem_stall", 32'(stall_all), 32'd0);
    step();
    check("fast_mem_state", 32'(state), 32'd0);

    // Timeout to ERROR, counter saturation, reset recovery
    mem_ready = 1'b0;
    for (int i = 0; i < TIMEOUT + 1; i++) step();
    check("timeout_state", 32'(state), 32'd2);
    check("timeout_error", 32'(mem_error), 32'd1);
    for (int i = 0; i < CNT_MAX + 5; i++) step();
    check("saturate", 32'(stall_count), CNT_MAX);
    do_reset();

    // Enable low freezes a memory wait
    mem_access_3_4 = 1'b1; mem_ready = 1'b0;
    step(); step(); step();
    saved = int'(stall_count);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("freeze_state", 32'(state), 32'd1);
    check("freeze_count", 32'(stall_count), 32'(saved));
    enable = 1'b1;
    for (int i = 0; i < TIMEOUT - 3; i++) step();
    check("freeze_pre_error", 32'(state), 32'd1);
    step();
    check("freeze_error", 32'(state), 32'd2);

    // Reset in the middle of a wait
    do_reset();
    mem_access_3_4 = 1'b1; mem_ready = 1'b0;
    step(); step();
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 49) do_reset();
      apply_random();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
